// File: rtl/ysyx_25030093_wbu_if.sv
// ysyx_25030093_wbu_if: execute-in, memory-response, regfile-write and commit signals of the writeback unit
interface ysyx_25030093_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [DATA_WIDTH-1:0] in_alu_result;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_next_pc;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rready;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  commit_valid;
  logic [DATA_WIDTH-1:0] commit_pc;
  logic [DATA_WIDTH-1:0] commit_next_pc;
  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_alu_result, in_is_load, in_funct3, in_addr_lo,
           in_pc, in_next_pc, mem_rvalid, mem_rdata,
    output in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, commit_next_pc
  );
  modport master (
    output in_valid, in_rd, in_rd_wen, in_alu_result, in_is_load, in_funct3, in_addr_lo,
           in_pc, in_next_pc, mem_rvalid, mem_rdata,
    input  in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, commit_next_pc
  );
endinterface

// File: rtl/ysyx_25030093_wbu.sv
// ysyx_25030093_wbu: writeback unit, formats load data and retires one instruction per commit pulse
module ysyx_25030093_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  ysyx_25030093_wbu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rd_wen_q, rd_wen_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] next_pc_q, next_pc_d;
  logic [7:0]            b_sel;
  logic [15:0]           h_sel;
  logic [DATA_WIDTH-1:0] load_data;
  // select the addressed byte/halfword of the response and extend it by load type
  always_comb begin
    b_sel = bus.mem_rdata[{addr_lo_q, 3'b000} +: 8];
    h_sel = bus.mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    load_data = funct3_q == 3'b000 ? {{(DATA_WIDTH-8){b_sel[7]}}, b_sel} :
                funct3_q == 3'b001 ? {{(DATA_WIDTH-16){h_sel[15]}}, h_sel} :
                funct3_q == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, b_sel} :
                funct3_q == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, h_sel} :
                bus.mem_rdata;
  end
  // next state: capture on accept, load result on memory response, return to idle after commit
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    rd_wen_d = rd_wen_q;
    result_d = result_q;
    funct3_d = funct3_q;
    addr_lo_d = addr_lo_q;
    pc_d = pc_q;
    next_pc_d = next_pc_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        rd_d = bus.in_rd;
        rd_wen_d = bus.in_rd_wen;
        result_d = bus.in_alu_result;
        funct3_d = bus.in_funct3;
        addr_lo_d = bus.in_addr_lo;
        pc_d = bus.in_pc;
        next_pc_d = bus.in_next_pc;
        state_d = bus.in_is_load ? WAIT_MEM : COMMIT;
      end
      WAIT_MEM: if (bus.mem_rvalid) begin
        result_d = load_data;
        state_d = COMMIT;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and captured-instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= '0;
      rd_wen_q <= 1'b0;
      result_q <= '0;
      funct3_q <= '0;
      addr_lo_q <= '0;
      pc_q <= '0;
      next_pc_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      rd_wen_q <= rd_wen_d;
      result_q <= result_d;
      funct3_q <= funct3_d;
      addr_lo_q <= addr_lo_d;
      pc_q <= pc_d;
      next_pc_q <= next_pc_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.mem_rready = state_q == WAIT_MEM;
  assign bus.commit_valid = state_q == COMMIT;
  assign bus.rf_wen = state_q == COMMIT && rd_wen_q && rd_q != '0;
  assign bus.rf_waddr = rd_q;
  assign bus.rf_wdata = result_q;
  assign bus.commit_pc = pc_q;
  assign bus.commit_next_pc = next_pc_q;
endmodule
